// File: rtl/ft245_pkg.sv
// ft245_pkg: shared types and default timing for the FT245 FIFO emulator.
package ft245_pkg;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DRIVE, R_PRECH} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_HIGH, W_PRECH} wr_state_e;
    localparam int RD_LAT_DEF = 2;
    localparam int PRECH_DEF  = 3;
    typedef logic [7:0] byte_t;
endpackage

// File: rtl/ft_sync_fifo.sv
// ft_sync_fifo: show-ahead byte FIFO; push and pop may coincide even when full or empty.
module ft_sync_fifo
    import ft245_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  byte_t                  din,
    output byte_t                  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    byte_t mem_q [DEPTH];
    logic [AW:0] wp_q, rp_q;
    logic do_push, do_pop;
    assign empty   = wp_q == rp_q;
    assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign level   = wp_q - rp_q;
    assign dout    = mem_q[rp_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    // a pop frees the slot the push lands in, so full + push + pop is legal
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk)
        if (do_push) mem_q[wp_q[AW-1:0]] <= din;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_q + PW'(do_push);
            rp_q <= rp_q + PW'(do_pop);
        end
    end
endmodule

// File: rtl/ft245_fifo_emu.sv
// ft245_fifo_emu: FT245-style async FIFO device model with host-side valid/ready streams.
module ft245_fifo_emu
    import ft245_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int PRECH  = PRECH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   FT_RXFn,
    output logic                   FT_TXEn,
    input  logic                   FT_RDn,
    input  logic                   FT_WR,
    output logic [7:0]             FT_DATA_In,
    input  logic [7:0]             FT_DATA_Out,
    input  logic [7:0]             host_rx_data,
    input  logic                   host_rx_valid,
    output logic                   host_rx_ready,
    output logic [7:0]             host_tx_data,
    output logic                   host_tx_valid,
    input  logic                   host_tx_ready,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic                   proto_err
);
    localparam int LW = $clog2(DEPTH) + 1;
    rd_state_e rd_q, rd_d;
    wr_state_e wr_q, wr_d;
    logic [7:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
    byte_t dat_q, dat_d, wdat_q, wdat_d, rx_head;
    logic rxf_q, rxf_d, txe_q, txe_d, pop_q, pop_d, push_q, push_d;
    logic err_q, rerr, werr, up_q, rd_arm_q, wr_prev_q;
    logic rx_full, rx_empty, tx_full, tx_empty, rx_none, tx_full_n, wr_rise;

    ft_sync_fifo #(.DEPTH(DEPTH)) u_rx (
        .clk(clk), .rst(rst), .push(host_rx_valid && host_rx_ready), .pop(pop_q),
        .din(host_rx_data), .dout(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );
    ft_sync_fifo #(.DEPTH(DEPTH)) u_tx (
        .clk(clk), .rst(rst), .push(push_q), .pop(host_tx_valid && host_tx_ready),
        .din(wdat_q), .dout(host_tx_data), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    assign FT_RXFn       = rxf_q;
    assign FT_TXEn       = txe_q;
    assign FT_DATA_In    = dat_q;
    assign proto_err     = err_q;
    assign host_rx_ready = up_q && !rx_full;
    assign host_tx_valid = !tx_empty;
    // transfers commit one cycle late, so look through a still-pending pop/push
    assign rx_none   = rx_empty || (pop_q && rx_level == LW'(1));
    assign tx_full_n = tx_full || (push_q && tx_level == LW'(DEPTH - 1));
    assign wr_rise   = FT_WR && !wr_prev_q;

    always_comb begin
        rd_d   = rd_q;
        rcnt_d = rcnt_q;
        rxf_d  = rxf_q;
        dat_d  = dat_q;
        pop_d  = 1'b0;
        rerr   = 1'b0;
        case (rd_q)
            R_IDLE: begin
                rxf_d = rx_none;
                if (rd_arm_q && !FT_RDn) begin
                    if (rx_empty) rerr = 1'b1;
                    else begin
                        rd_d   = R_WAIT;
                        rcnt_d = '0;
                        rxf_d  = 1'b0;
                    end
                end
            end
            R_WAIT: begin
                if (FT_RDn) begin
                    pop_d  = 1'b1;
                    rerr   = 1'b1;
                    rxf_d  = 1'b1;
                    rd_d   = R_PRECH;
                    rcnt_d = '0;
                end else if (rcnt_q == 8'(RD_LAT - 1)) begin
                    dat_d = rx_head;
                    rd_d  = R_DRIVE;
                end else rcnt_d = rcnt_q + 8'd1;
            end
            R_DRIVE: begin
                if (FT_RDn) begin
                    pop_d  = 1'b1;
                    rxf_d  = 1'b1;
                    rd_d   = R_PRECH;
                    rcnt_d = '0;
                end
            end
            R_PRECH: begin
                if (rcnt_q == 8'(PRECH - 1)) begin
                    rd_d  = R_IDLE;
                    rxf_d = rx_none;
                end else rcnt_d = rcnt_q + 8'd1;
            end
        endcase
    end

    always_comb begin
        wr_d   = wr_q;
        wcnt_d = wcnt_q;
        txe_d  = txe_q;
        wdat_d = wdat_q;
        push_d = 1'b0;
        werr   = wr_rise && txe_q;
        case (wr_q)
            W_IDLE: begin
                txe_d = tx_full;
                if (wr_rise && !txe_q) begin
                    wr_d  = W_HIGH;
                    txe_d = 1'b0;
                end
            end
            W_HIGH: begin
                if (!FT_WR) begin
                    push_d = 1'b1;
                    wdat_d = FT_DATA_Out;
                    txe_d  = 1'b1;
                    wr_d   = W_PRECH;
                    wcnt_d = '0;
                end
            end
            W_PRECH: begin
                if (wcnt_q == 8'(PRECH - 1)) begin
                    wr_d  = W_IDLE;
                    txe_d = tx_full_n;
                end else wcnt_d = wcnt_q + 8'd1;
            end
            default: wr_d = W_IDLE;
        endcase
    end

    // strobes held through reset stay ignored until seen inactive (rd_arm_q, wr_prev_q)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q      <= R_IDLE;
            wr_q      <= W_IDLE;
            rcnt_q    <= '0;
            wcnt_q    <= '0;
            rxf_q     <= 1'b1;
            txe_q     <= 1'b1;
            dat_q     <= '0;
            wdat_q    <= '0;
            pop_q     <= 1'b0;
            push_q    <= 1'b0;
            err_q     <= 1'b0;
            up_q      <= 1'b0;
            rd_arm_q  <= 1'b0;
            wr_prev_q <= 1'b1;
        end else begin
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            rcnt_q    <= rcnt_d;
            wcnt_q    <= wcnt_d;
            rxf_q     <= rxf_d;
            txe_q     <= txe_d;
            dat_q     <= dat_d;
            wdat_q    <= wdat_d;
            pop_q     <= pop_d;
            push_q    <= push_d;
            err_q     <= err_q || rerr || werr;
            up_q      <= 1'b1;
            rd_arm_q  <= rd_arm_q || FT_RDn;
            wr_prev_q <= FT_WR;
        end
    end
endmodule

// File: tb/tb_ft245_fifo_emu.sv
// tb_ft245_fifo_emu: directed and randomized checks against a queue-based device model.
module tb_ft245_fifo_emu;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 2;
    localparam int PRECH  = 3;

    logic clk, rst, rdn, wr, rxfn, txen, hrx_valid, hrx_ready, htx_valid, htx_ready, perr;
    logic [7:0] din, dout, hrx_data, htx_data, last_din;
    logic [4:0] rx_level, tx_level;
    logic [7:0] rxq [$];
    logic [7:0] txq [$];
    int checks, failures;

    ft245_fifo_emu #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .PRECH(PRECH)) dut (
        .clk(clk), .rst(rst), .FT_RXFn(rxfn), .FT_TXEn(txen), .FT_RDn(rdn), .FT_WR(wr),
        .FT_DATA_In(din), .FT_DATA_Out(dout), .host_rx_data(hrx_data), .host_rx_valid(hrx_valid),
        .host_rx_ready(hrx_ready), .host_tx_data(htx_data), .host_tx_valid(htx_valid),
        .host_tx_ready(htx_ready), .rx_level(rx_level), .tx_level(tx_level), .proto_err(perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_push(input logic [7:0] b);
        chk("rx_ready", hrx_ready, 1);
        hrx_data  = b;
        hrx_valid = 1'b1;
        tick;
        hrx_valid = 1'b0;
        rxq.push_back(b);
        chk("rx_level_push", rx_level, rxq.size());
    endtask

    task automatic host_pop;
        chk("tx_valid", htx_valid, 1);
        chk("tx_data", htx_data, txq[0]);
        htx_ready = 1'b1;
        tick;
        htx_ready = 1'b0;
        void'(txq.pop_front());
        chk("tx_level_pop", tx_level, txq.size());
    endtask

    task automatic ctrl_read(input int hold);
        int t = 0;
        int n0;
        logic [7:0] exp;
        while (rxfn !== 1'b0 && t < 50) begin tick; t++; end
        chk("rxf_wait", rxfn, 0);
        exp = rxq[0];
        n0  = rxq.size();
        rdn = 1'b0;
        for (int k = 1; k <= hold; k++) begin
            tick;
            if (k == RD_LAT + 1) chk("rd_data", din, exp);
        end
        rdn = 1'b1;
        tick;
        chk("rxf_release", rxfn, 1);
        chk("rx_level_hold", rx_level, n0);
        if (hold > RD_LAT) last_din = exp;
        else chk("short_err", perr, 1);
        chk("din_hold", din, last_din);
        void'(rxq.pop_front());
        for (int j = 1; j <= PRECH; j++) begin
            tick;
            if (j == 1) chk("rx_level_dec", rx_level, rxq.size());
            chk("rxf_prech", rxfn, (j < PRECH) || (rxq.size() == 0));
        end
    endtask

    task automatic ctrl_write(input logic [7:0] b);
        int t = 0;
        int n0;
        while (txen !== 1'b0 && t < 50) begin tick; t++; end
        chk("txe_wait", txen, 0);
        n0   = txq.size();
        wr   = 1'b1;
        dout = ~b;
        tick;
        dout = b;
        wr   = 1'b0;
        tick;
        chk("txe_release", txen, 1);
        chk("tx_level_hold", tx_level, n0);
        txq.push_back(b);
        for (int j = 1; j <= PRECH; j++) begin
            tick;
            if (j == 1) begin
                chk("tx_level_inc", tx_level, txq.size());
                chk("tx_valid_wr", htx_valid, 1);
            end
            chk("txe_prech", txen, (j < PRECH) || (txq.size() == DEPTH));
        end
    endtask

    task automatic model_reset;
        rxq.delete();
        txq.delete();
        last_din = 8'h00;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; rdn = 1'b1; wr = 1'b0; dout = 8'h00;
        hrx_data = 8'h00; hrx_valid = 1'b0; htx_ready = 1'b0;
        model_reset;
        tick; tick;
        chk("rst_rxf", rxfn, 1);
        chk("rst_txe", txen, 1);
        chk("rst_din", din, 0);
        chk("rst_rx_ready", hrx_ready, 0);
        chk("rst_tx_valid", htx_valid, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_err", perr, 0);
        rst = 1'b0;
        tick;
        chk("rx_ready_up", hrx_ready, 1);

        host_push(8'd25);
        chk("rxf_push_lat0", rxfn, 1);
        tick;
        chk("rxf_push_lat1", rxfn, 0);
        ctrl_read(4);
        tick; tick;
        chk("rx_empty_after", rx_level, 0);
        chk("rxf_empty_after", rxfn, 1);

        host_push(8'd1); host_push(8'd2); host_push(8'd3);
        for (int i = 0; i < 3; i++) ctrl_read(4);

        for (int i = 0; i < 16; i++) ctrl_write(8'(i));
        tick;
        chk("txe_full", txen, 1);
        chk("err_before_drop", perr, 0);
        wr = 1'b1; dout = 8'hAA;
        tick;
        wr = 1'b0;
        tick; tick;
        chk("drop_err", perr, 1);
        chk("drop_level", tx_level, 16);
        for (int i = 0; i < 16; i++) host_pop;
        chk("tx_drained", htx_valid, 0);
        tick;
        chk("txe_after_drain", txen, 0);

        rst = 1'b1;
        #2;
        chk("err_cleared", perr, 0);
        tick;
        rst = 1'b0;
        model_reset;
        tick;
        rdn = 1'b0;
        tick; tick;
        rdn = 1'b1;
        tick;
        chk("empty_rd_err", perr, 1);
        chk("empty_rd_level", rx_level, 0);
        chk("empty_rd_din", din, 0);

        host_push(8'h5A); host_push(8'h6B);
        tick;
        rdn = 1'b0;
        for (int k = 0; k <= RD_LAT; k++) tick;
        chk("drive_data", din, 8'h5A);
        rst = 1'b1;
        #2;
        chk("midrst_rxf", rxfn, 1);
        chk("midrst_level", rx_level, 0);
        chk("midrst_din", din, 0);
        tick;
        rst = 1'b0;
        model_reset;
        tick;
        host_push(8'h77);
        for (int k = 0; k < 4; k++) tick;
        chk("held_no_pop", rx_level, 1);
        chk("held_no_err", perr, 0);
        chk("held_rxf", rxfn, 0);
        rdn = 1'b1;
        tick;
        ctrl_read(4);

        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: if (rxq.size() < DEPTH) host_push(8'($urandom));
                1: if (rxq.size() > 0) ctrl_read(int'($urandom_range(1, 5)));
                2: if (txq.size() < DEPTH) ctrl_write(8'($urandom));
                default: if (txq.size() > 0) host_pop;
            endcase
        end
        while (txq.size() > 0) host_pop;
        while (rxq.size() > 0) ctrl_read(4);
        chk("final_rx_level", rx_level, 0);
        chk("final_tx_level", tx_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
